// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   fetch_state_e    : outstanding-request tracking (IDLE / WAIT / WAIT_DROP)
//   NOP_WORD         : instruction word presented to decode in a bubble slot
//   RESET_PC_DEFAULT : default program counter after reset
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,  // no request outstanding
        WAIT      = 2'd1,  // one request outstanding, its data will be kept
        WAIT_DROP = 2'd2   // one request outstanding, its data will be discarded
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0;

    localparam int unsigned RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between instruction memory and the IR stage.
// Synchronous FIFO with wrap-around pointers; clear beats push.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : empty the buffer (pointers and count to zero)
//   push, wdata   : write one entry (caller guarantees not full unless popping)
//   pop           : remove the head entry (ignored when empty)
//   rdata         : head entry, valid while count != 0
//   count         : number of stored entries
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_pop;

    // Explicit wrap so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues single outstanding word reads, buffers
// returned words in a prefetch FIFO and feeds IR / PC_1 / flush to decode.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   stall                    : decode hold, IR stage keeps its contents
//   redirect_en, redirect_pc : taken branch/jump, new fetch target
//   imem_req, imem_addr      : read request (combinational) and address (= PC)
//   imem_ready               : memory accepts when imem_req & imem_ready
//   imem_rvalid, imem_rdata  : in-order read response
//   IR, PC_1, flush          : instruction, its address + 1, bubble marker
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     IR,
    output logic [PC_W-1:0] PC_1,
    output logic            flush
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 32 + PC_W;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_1_q, pc_1_d;
    logic            flush_q, flush_d;

    logic [CNT_W-1:0] fifo_count;
    logic [ENT_W-1:0] fifo_head;
    logic [ENT_W-1:0] push_data;
    logic             pop;
    logic             push;
    logic             busy;
    logic             room;
    logic             accept;
    logic [CNT_W:0]   occupancy;

    // Request/handshake decode.
    always_comb begin
        pop       = !stall && !redirect_en && (fifo_count != '0);
        busy      = (state_q != IDLE);
        // Entries held after this cycle plus the slot reserved for the
        // outstanding response; a new request needs one more free slot.
        occupancy = {1'b0, fifo_count} - (CNT_W+1)'(pop) + (CNT_W+1)'(busy);
        room      = occupancy < (CNT_W+1)'(FIFO_DEPTH);
        imem_req  = !redirect_en && room &&
                    ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid));
        accept    = imem_req && imem_ready;
        push      = (state_q == WAIT) && imem_rvalid && !redirect_en;
        // While WAIT (no redirect since issue) the PC already points one
        // past the outstanding address, which is exactly PC_1 for that word.
        push_data = {imem_rdata, pc_q};
    end

    // Outstanding-request FSM and PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_en) begin
                    state_d = imem_rvalid ? IDLE : WAIT_DROP;
                end else if (imem_rvalid) begin
                    state_d = accept ? WAIT : IDLE;
                end
            end
            WAIT_DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_en) begin
            pc_d = redirect_pc;
        end else if (accept) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // IR stage: redirect forces a bubble even under stall.
    always_comb begin
        ir_d    = ir_q;
        pc_1_d  = pc_1_q;
        flush_d = flush_q;
        if (redirect_en) begin
            ir_d    = NOP_WORD;
            flush_d = 1'b1;
        end else if (!stall) begin
            if (fifo_count != '0) begin
                ir_d    = fifo_head[ENT_W-1:PC_W];
                pc_1_d  = fifo_head[PC_W-1:0];
                flush_d = 1'b0;
            end else begin
                ir_d    = NOP_WORD;
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_WORD;
            pc_1_q  <= '0;
            flush_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc_1_q  <= pc_1_d;
            flush_q <= flush_d;
        end
    end

    fetch_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_en),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign imem_addr = pc_q;
    assign IR        = ir_q;
    assign PC_1      = pc_1_q;
    assign flush     = flush_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int PC_W       = 32;
    localparam int FIFO_DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            redirect_en;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic [31:0]     ir_w;
    logic [PC_W-1:0] pc_1_w;
    logic            flush_w;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .PC_W       (PC_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .IR          (ir_w),
        .PC_1        (pc_1_w),
        .flush       (flush_w)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction memory image.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    // Memory responder state (single outstanding read).
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat_min, lat_max;

    // Reference model: next fetch address and next expected decoded address.
    logic [31:0] exp_fetch, exp_dec;
    bit          upd_prev, expect_bubble;
    logic [31:0] prev_ir, prev_pc1;
    logic        prev_flush;
    int          n_dec;

    // Samples of the last completed cycle.
    logic        s_req, s_flush;
    logic [31:0] s_addr, s_ir, s_pc1;

    task automatic model_reset();
        exp_fetch     = 32'h0;
        exp_dec       = 32'h0;
        upd_prev      = 1'b1;
        expect_bubble = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, observe at negedge, advance models.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] tgt, input bit rdy);
        bit          acc;
        logic [31:0] e1;
        stall       = st;
        redirect_en = rd;
        redirect_pc = tgt;
        imem_ready  = rdy;
        if (pend && pend_cnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_ir    = ir_w;
        s_pc1   = pc_1_w;
        s_flush = flush_w;

        if (s_flush) check_eq("bubble_is_nop", s_ir, 32'h0);
        if (!upd_prev) begin
            check_eq("stall_hold_ir", s_ir, prev_ir);
            check_eq("stall_hold_pc_1", s_pc1, prev_pc1);
            check_eq("stall_hold_flush", s_flush, prev_flush);
        end else if (expect_bubble) begin
            check_eq("redirect_bubble", s_flush, 1'b1);
        end else if (!s_flush) begin
            e1 = exp_dec + 32'd1;
            check_eq("ir_stream", s_ir, mem_word(exp_dec));
            check_eq("pc_1_stream", s_pc1, e1);
            exp_dec = e1;
            n_dec++;
        end
        if (rd) check_eq("req_blocked_by_redirect", s_req, 1'b0);
        if (s_req) check_eq("fetch_addr", s_addr, exp_fetch);
        acc = s_req && rdy;
        check_eq("one_outstanding", acc && pend && !imem_rvalid, 1'b0);
        check_eq("fifo_no_overflow",
                 dut.push && !dut.pop && (int'(dut.fifo_count) == FIFO_DEPTH), 1'b0);

        if (imem_rvalid) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_cnt  = $urandom_range(lat_max, lat_min);
        end
        if (rd) begin
            exp_fetch = tgt;
            exp_dec   = tgt;
        end else if (acc) begin
            exp_fetch = exp_fetch + 32'd1;
        end
        upd_prev      = !st || rd;
        expect_bubble = rd;
        prev_ir       = s_ir;
        prev_pc1      = s_pc1;
        prev_flush    = s_flush;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int n0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        pend_cnt    = 0;
        pend_addr   = '0;
        n_dec       = 0;
        lat_min     = 1;
        lat_max     = 1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ir", ir_w, 32'h0);
        check_eq("rst_pc_1", pc_1_w, 32'h0);
        check_eq("rst_flush", flush_w, 1'b1);
        check_eq("rst_addr", imem_addr, 32'h0);
        model_reset();
        rst = 1'b0;

        // Start-up latency with a 1-cycle memory.
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check_eq("t1_req", s_req, 1'b1);
            check_eq("t1_addr", s_addr, c);
            if (c < 3) begin
                check_eq("t1_flush", s_flush, 1'b1);
            end else begin
                check_eq("t1_flush", s_flush, 1'b0);
                check_eq("t1_ir", s_ir, mem_word(c - 3));
                check_eq("t1_pc_1", s_pc1, c - 2);
            end
        end

        // Stall for 5 cycles: IR frozen on mem[7], requests stop once full.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            check_eq("t2_frozen_ir", s_ir, mem_word(7));
            check_eq("t2_req_off", s_req, 1'b0);
        end
        check_eq("t2_fifo_full", dut.fifo_count, FIFO_DEPTH);
        for (int j = 0; j < 4; j++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check_eq("t2_release_flush", s_flush, 1'b0);
            check_eq("t2_release_ir", s_ir, mem_word(7 + j));
        end

        // Redirect to 0x40 while a response is arriving.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (pend && pend_cnt == 1) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check_eq("t3_setup", found, 1'b1);
        cycle(1'b0, 1'b1, 32'h40, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (j == 1) begin
                check_eq("t3_req", s_req, 1'b1);
                check_eq("t3_addr", s_addr, 32'h40);
            end
            if (j <= 3) begin
                check_eq("t3_flush", s_flush, 1'b1);
            end else begin
                check_eq("t3_flush_end", s_flush, 1'b0);
                check_eq("t3_ir", s_ir, mem_word(32'h40));
                check_eq("t3_pc_1", s_pc1, 32'h41);
            end
        end

        // Redirect while WAIT with the response still in flight (drop path).
        lat_min = 2;
        lat_max = 2;
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (pend && pend_cnt > 1) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check_eq("t3b_setup", found, 1'b1);
        cycle(1'b0, 1'b1, 32'h80, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (!s_flush) begin
                found = 1'b1;
                check_eq("t3b_ir", s_ir, mem_word(32'h80));
                check_eq("t3b_pc_1", s_pc1, 32'h81);
            end
        end
        check_eq("t3b_seen", found, 1'b1);

        // Redirect together with rvalid while stalled.
        lat_min = 1;
        lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (pend && pend_cnt == 1) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check_eq("t4_setup", found, 1'b1);
        cycle(1'b1, 1'b1, 32'h123, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("t4_flush", s_flush, 1'b1);
        check_eq("t4_ir", s_ir, 32'h0);
        check_eq("t4_req", s_req, 1'b1);
        check_eq("t4_addr", s_addr, 32'h123);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Random ready / latency / stall / redirects.
        lat_min = 3;
        lat_max = 5;
        n0 = n_dec;
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 40) == 0, $urandom, ($urandom % 4) != 0);
        end
        check_eq("t5_progress", (n_dec - n0) > 100, 1'b1);

        // Asynchronous reset while a request is outstanding.
        cycle(1'b0, 1'b1, 32'h200, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend && pend_cnt > 1) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check_eq("t6_setup", found, 1'b1);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("t6_ir", ir_w, 32'h0);
        check_eq("t6_flush", flush_w, 1'b1);
        check_eq("t6_pc_1", pc_1_w, 32'h0);
        check_eq("t6_addr", imem_addr, 32'h0);
        check_eq("t6_req", imem_req, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        pend_cnt = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("t6_late_req", s_req, 1'b1);
        check_eq("t6_late_addr", s_addr, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (!s_flush) begin
                found = 1'b1;
                check_eq("t6_first_ir", s_ir, mem_word(32'h0));
                check_eq("t6_first_pc_1", s_pc1, 32'h1);
            end
        end
        check_eq("t6_seen", found, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
